// File: rtl/hl2link_pkg.sv
// hl2link_pkg: shared types and constants for the hl2link transmit queue.
//   state_t  : sender FSM states (IDLE / SEND_I / SEND_Q)
//   DEPTH    : FIFO depth in samples
//   SAMPLE_W : sample width, {I[47:24], Q[23:0]}
//   WORD_W   : link word width
package hl2link_pkg;

   localparam int DEPTH    = 16;
   localparam int SAMPLE_W = 48;
   localparam int WORD_W   = 24;
   localparam int PTR_W    = 4;
   localparam int LEVEL_W  = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_I = 2'd1,
      SEND_Q = 2'd2
   } state_t;

   function automatic logic [WORD_W-1:0] get_i(input logic [SAMPLE_W-1:0] s);
      return s[SAMPLE_W-1:WORD_W];
   endfunction

   function automatic logic [WORD_W-1:0] get_q(input logic [SAMPLE_W-1:0] s);
      return s[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/hl2link_fifo16.sv
// hl2link_fifo16: 16-deep sample FIFO, synchronous write, asynchronous read.
//   clk, rst  : clock, synchronous active-high reset (pointers and level only)
//   i_flush   : empties the FIFO on the next edge
//   i_wr      : write i_wdata (caller guarantees not full)
//   i_rd      : pop the head (caller guarantees not empty)
//   o_head    : current head sample
//   o_next    : sample behind the head (valid when o_level > 1)
//   o_level   : occupancy 0..16
module hl2link_fifo16 import hl2link_pkg::*; (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_flush,
   input  logic                i_wr,
   input  logic [SAMPLE_W-1:0] i_wdata,
   input  logic                i_rd,
   output logic [SAMPLE_W-1:0] o_head,
   output logic [SAMPLE_W-1:0] o_next,
   output logic [LEVEL_W-1:0]  o_level
);

   // Storage has no reset so it maps onto distributed RAM.
   logic [SAMPLE_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [LEVEL_W-1:0]  r_level;
   logic [PTR_W-1:0]    w_next_ptr;

   always_ff @(posedge clk) begin
      if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_wr) r_wr_ptr <= r_wr_ptr + 4'd1;
         if (i_rd) r_rd_ptr <= r_rd_ptr + 4'd1;
         // Push and pop together cancel out.
         r_level <= r_level + {4'd0, i_wr} - {4'd0, i_rd};
      end
   end

   // Pointer arithmetic is 4 bits wide, so it wraps modulo 16.
   assign w_next_ptr = r_rd_ptr + 4'd1;
   assign o_head     = r_mem[r_rd_ptr];
   assign o_next     = r_mem[w_next_ptr];
   assign o_level    = r_level;

endmodule

// File: rtl/hl2link_txq.sv
// hl2link_txq: buffers 48-bit I/Q samples and serialises each one as two
// 24-bit link words (I first, then Q).
//   clk, rst     : clock, synchronous active-high reset
//   enable       : link running and slave side; low flushes everything
//   s_tdata/s_tvalid/s_tready : sample input stream
//   ls_data/ls_valid/ls_done  : link sender word interface
//   level        : FIFO occupancy 0..16
//   overflow     : sticky, a sample was offered while full
//   ovf_clear    : clears overflow
//   o_dbg_state  : current sender FSM state
//
// Handshakes: a sample moves when s_tvalid & s_tready at a rising edge.
// A link word is held on ls_data with ls_valid=1 until the one-cycle
// ls_done pulse; ls_done while ls_valid=0 has no effect.
module hl2link_txq import hl2link_pkg::*; (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   output logic [WORD_W-1:0]   ls_data,
   output logic                ls_valid,
   input  logic                ls_done,
   output logic [LEVEL_W-1:0]  level,
   output logic                overflow,
   input  logic                ovf_clear,
   output state_t              o_dbg_state
);

   state_t              r_state;
   logic [WORD_W-1:0]   r_ls_data;
   logic                r_ls_valid;
   logic                r_overflow;
   logic [SAMPLE_W-1:0] w_head;
   logic [SAMPLE_W-1:0] w_next;
   logic [LEVEL_W-1:0]  w_level;
   logic                w_full;
   logic                w_push;
   logic                w_pop;

   // Ready comes from registered level only; a pop in this cycle does not
   // free a slot until the next cycle.
   assign w_full   = (w_level == LEVEL_W'(DEPTH));
   assign s_tready = ~rst & enable & ~w_full;
   assign w_push   = s_tvalid & s_tready;
   // Flush (enable low) overrides a coincident ls_done.
   assign w_pop    = enable & (r_state == SEND_Q) & ls_done;

   hl2link_fifo16 u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (~enable),
      .i_wr    (w_push),
      .i_wdata (s_tdata),
      .i_rd    (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_level (w_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ls_data  <= '0;
         r_ls_valid <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         // Set wins over clear.
         if (s_tvalid && enable && w_full) r_overflow <= 1'b1;
         else if (ovf_clear)               r_overflow <= 1'b0;

         if (!enable) begin
            r_state    <= IDLE;
            r_ls_valid <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_level != '0) begin
                     r_ls_data  <= get_i(w_head);
                     r_ls_valid <= 1'b1;
                     r_state    <= SEND_I;
                  end
               end
               SEND_I: begin
                  if (ls_done) begin
                     r_ls_data <= get_q(w_head);
                     r_state   <= SEND_Q;
                  end
               end
               SEND_Q: begin
                  if (ls_done) begin
                     // The head is popped on this edge, so the next I word
                     // comes from the entry behind it.
                     if (w_level > 5'd1) begin
                        r_ls_data <= get_i(w_next);
                        r_state   <= SEND_I;
                     end else begin
                        r_ls_valid <= 1'b0;
                        r_state    <= IDLE;
                     end
                  end
               end
               default: begin
                  r_ls_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            endcase
         end
      end
   end

   assign ls_data     = r_ls_data;
   assign ls_valid    = r_ls_valid;
   assign overflow    = r_overflow;
   assign level       = w_level;
   assign o_dbg_state = r_state;

endmodule
